adder_sweep_ctrl: RTL and testbench
===================================

Name: adder_sweep_ctrl

Overview:
Operand sequencer and result checker for the dual RCA/CLA adder datapath. It drives a, b, Cin, sel and load into the datapath and sweeps all 512 operand combinations, once with sel=0 (RCA) and once with sel=1 (CLA). It samples the packed 10-bit Q for each pass and checks it against a golden sum. It reports the mismatch count, the first failing vector and a pass flag.

Parameters:
HOLD, 4, cycles load/operands/sel are held per phase before sampling Q (must be >= datapath load-to-Q latency; legal 1..15)
LAST_VEC, 511, final vector index of the sweep (reduce for short sims)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin sweep; sampled in IDLE and DONE only
Q  input  10  datapath result: [4:0] RCA field, [9:5] CLA field
a  output  4  operand A to datapath
b  output  4  operand B to datapath
Cin  output  1  carry-in to datapath
sel  output  1  0 = RCA phase, 1 = CLA phase
load  output  1  datapath load enable
busy  output  1  sweep in progress
done  output  1  sweep finished, results valid
pass  output  1  done && err_cnt==0
err_cnt  output  11  number of failing phase samples (max 1024, no saturation needed)
first_err_vec  output  9  {Cin,a,b} of first failure
first_err_phase  output  1  sel value of first failure
first_err_valid  output  1  first_err_* captured

Behaviour:
- Reset (rst_n=0 at posedge, any state): state=IDLE; all outputs 0; vector and hold counters 0. No auto-restart after reset release.
- Vector index vec[8:0] = {Cin,a,b}, b in LSBs. Outputs a/b/Cin are registered copies of vec.
- States: IDLE, DRIVE_R, SAMPLE_R, DRIVE_C, SAMPLE_C, DONE.
- IDLE: busy=0, load=0. On start=1: clear err_cnt, first_err_*, done; vec=0; go to DRIVE_R.
- DRIVE_R: sel=0, load=1, busy=1 for exactly HOLD cycles (hold counter), then SAMPLE_R.
- SAMPLE_R (1 cycle): load=0, sel=0. Expected Q = {5'b0, exp}, where exp = a+b+Cin (5-bit, 0..31). Then DRIVE_C.
- DRIVE_C: sel=1, load=1 for HOLD cycles, then SAMPLE_C.
- SAMPLE_C (1 cycle): load=0, sel=1. Expected Q = {exp, 5'b0}. Then DONE if vec==LAST_VEC, else vec+1 and DRIVE_R.
- The full 10-bit Q is compared, so stale or misplaced bits in the inactive field count as failures.
- On a mismatch: err_cnt+1. If first_err_valid=0, capture vec and sel into first_err_vec/first_err_phase and set first_err_valid.
- Phase timing: each vector takes 2*(HOLD+1) cycles. Default full sweep takes 5120 cycles from the start-accept edge to the DONE entry edge.
- DONE: busy=0, done=1, load=0. Results hold until reset or start. start=1 restarts as in IDLE and clears done on the accepting edge.
- start while busy: ignored, with no effect on the count.
- Operands and sel change only on DRIVE_R/DRIVE_C entry and never during a hold window.

Test Plan:
- Reset, then start with an ideal datapath model (HOLD=4) -> busy high 5120 cycles; then done=1, pass=1, err_cnt=0, first_err_valid=0.
- Model with CLA result bit0 stuck at 0 -> err_cnt=256, first_err_vec=9'd1, first_err_phase=1, pass=0.
- Model that leaves the RCA field unzeroed during CLA phase -> err_cnt=511 (vec 0 passes), first_err_vec=9'd1, first_err_phase=1.
- Boundary vector 511 (a=F, b=F, Cin=1): Q sampled as 10'h01F in SAMPLE_R and 10'h3E0 in SAMPLE_C -> no error recorded.
- rst_n=0 for 1 cycle at cycle 1000 of the sweep -> next cycle state IDLE, all outputs 0, err_cnt=0; no activity until start.
- start pulsed mid-sweep -> ignored, completion still at cycle 5120. Then start in DONE after the stuck-bit run -> err_cnt 256 to 0, done 1 to 0 on the accept edge.

Source files
------------

// File: rtl/adder_sweep_ctrl_if.sv
// Operand/result bus between the sweep controller and the dual RCA/CLA adder datapath.
interface adder_sweep_ctrl_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       Cin;
  logic       sel;
  logic       load;
  logic [9:0] Q;

  modport master (output a, b, Cin, sel, load, input Q);
  modport slave  (input a, b, Cin, sel, load, output Q);
endinterface

// File: rtl/adder_sweep_ctrl.sv
// Sweeps all {Cin,a,b} vectors through the adder datapath, once per adder (RCA then CLA),
// and checks every packed 10-bit result against a golden sum.
module adder_sweep_ctrl #(
  parameter int unsigned HOLD     = 4,
  parameter int unsigned LAST_VEC = 511
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  adder_sweep_ctrl_if.master   dp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [10:0]          err_cnt,
  output logic [8:0]           first_err_vec,
  output logic                 first_err_phase,
  output logic                 first_err_valid
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE_R,
    SAMPLE_R,
    DRIVE_C,
    SAMPLE_C,
    DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [8:0] VEC_LAST  = 9'(LAST_VEC);

  state_t     state;
  state_t     state_nxt;
  logic [8:0] vec;
  logic [3:0] hold_cnt;
  logic       accept;
  logic       sampling;
  logic [4:0] gold_sum;
  logic [9:0] gold_q;

  // Operands are the vector register itself, so they only move when vec does
  assign dp.Cin = vec[8];
  assign dp.a   = vec[7:4];
  assign dp.b   = vec[3:0];

  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign sampling = (state == SAMPLE_R) || (state == SAMPLE_C);
  assign gold_sum = 5'(dp.a) + 5'(dp.b) + 5'(dp.Cin);
  assign gold_q   = (state == SAMPLE_C) ? {gold_sum, 5'b0} : {5'b0, gold_sum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE_R;
      DRIVE_R:    if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE_R;
      SAMPLE_R:   state_nxt = DRIVE_C;
      DRIVE_C:    if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE_C;
      SAMPLE_C:   state_nxt = (vec == VEC_LAST) ? DONE : DRIVE_R;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    dp.load = 1'b0;
    dp.sel  = 1'b0;
    unique case (state)
      IDLE:     ;
      DRIVE_R:  begin busy = 1'b1; dp.load = 1'b1; end
      SAMPLE_R: busy = 1'b1;
      DRIVE_C:  begin busy = 1'b1; dp.load = 1'b1; dp.sel = 1'b1; end
      SAMPLE_C: begin busy = 1'b1; dp.sel = 1'b1; end
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec             <= '0;
      hold_cnt        <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_phase <= 1'b0;
      first_err_valid <= 1'b0;
    end else if (accept) begin
      vec             <= '0;
      hold_cnt        <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_phase <= 1'b0;
      first_err_valid <= 1'b0;
    end else begin
      if (dp.load) begin
        hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 4'd1;
      end
      if (sampling && (dp.Q != gold_q)) begin
        err_cnt <= err_cnt + 11'd1;
        if (!first_err_valid) begin
          first_err_vec   <= vec;
          first_err_phase <= dp.sel;
          first_err_valid <= 1'b1;
        end
      end
      if ((state == SAMPLE_C) && (vec != VEC_LAST)) begin
        vec <= vec + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Bench for adder_sweep_ctrl: behavioural adder datapath with selectable faults plus result scoreboard.
module tb_adder_sweep_ctrl;

  localparam int unsigned HOLD  = 4;
  localparam int          SWEEP = 5120;

  typedef struct {
    int         err;
    logic [8:0] vec;
    logic       phase;
    logic       valid;
    logic       pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [10:0] err_cnt;
  logic [8:0]  first_err_vec;
  logic        first_err_phase, first_err_valid;

  adder_sweep_ctrl_if dp ();

  adder_sweep_ctrl #(.HOLD(HOLD), .LAST_VEC(511)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dp(dp),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_phase(first_err_phase),
    .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mode = 0;   // 0 ideal, 1 CLA bit0 stuck at 0, 2 RCA field left in CLA phase
  exp_t sb[$];

  function automatic logic [4:0] gold(input logic [3:0] x, input logic [3:0] y, input logic c);
    return 5'(x) + 5'(y) + 5'(c);
  endfunction

  // Datapath model: one-cycle load-to-Q latency
  always @(posedge clk) begin
    if (dp.load) begin
      if (!dp.sel) dp.Q <= {5'b0, gold(dp.a, dp.b, dp.Cin)};
      else if (mode == 1) dp.Q <= {gold(dp.a, dp.b, dp.Cin) & 5'b11110, 5'b0};
      else if (mode == 2) dp.Q <= {gold(dp.a, dp.b, dp.Cin), dp.Q[4:0]};
      else dp.Q <= {gold(dp.a, dp.b, dp.Cin), 5'b0};
    end
  end

  int         mon_err = 0;
  int         hold_viol = 0;
  int         streak = 0;
  logic       prev_load = 1'b0;
  logic [9:0] prev_ops = '0;
  logic [9:0] last_r_q = '0;
  logic [9:0] last_c_q = '0;

  always @(negedge clk) begin
    if (busy && !dp.load) begin
      if (dp.Q !== (dp.sel ? {gold(dp.a, dp.b, dp.Cin), 5'b0} : {5'b0, gold(dp.a, dp.b, dp.Cin)}))
        mon_err = mon_err + 1;
      if ({dp.Cin, dp.a, dp.b} == 9'h1FF) begin
        if (dp.sel) last_c_q = dp.Q;
        else last_r_q = dp.Q;
      end
    end
    if (dp.load && prev_load && ({dp.Cin, dp.a, dp.b, dp.sel} != prev_ops)) hold_viol = hold_viol + 1;
    if (dp.load) streak = streak + 1;
    else begin
      if (prev_load && (streak != HOLD)) hold_viol = hold_viol + 1;
      streak = 0;
    end
    prev_load = dp.load;
    prev_ops  = {dp.Cin, dp.a, dp.b, dp.sel};
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, pass, err_cnt, first_err_vec, first_err_phase, first_err_valid,
         dp.a, dp.b, dp.Cin, dp.sel, dp.load} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b err_cnt=%0d load=%b, required all zero",
               busy, done, err_cnt, dp.load);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || dp.load !== 1'b0) begin
      bad++;
      $display("FAIL no_autostart: busy=%b load=%b, required 0 0", busy, dp.load);
    end
  endtask

  task automatic run_sweep(input string name, input int m, input exp_t e, input bit poke);
    int   cyc;
    exp_t got;
    mode = m;
    sb.push_back(e);
    @(negedge clk);
    mon_err = 0;
    hold_viol = 0;
    start = 1'b1;
    cyc = 0;
    for (int i = 0; i < SWEEP + 200; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (poke && cyc == 2000) start = 1'b1;
      if (poke && cyc == 2003) start = 1'b0;
      if (busy) cyc++;
      if (done) break;
    end
    got = sb.pop_front();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: done=%b after %0d busy cycles, required done=1", name, done, cyc);
    end
    total++;
    if (cyc != SWEEP) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, cyc, SWEEP);
    end
    total++;
    if (int'(err_cnt) != got.err) begin
      bad++;
      $display("FAIL %s_err_cnt: got %0d, required %0d", name, err_cnt, got.err);
    end
    total++;
    if ({first_err_valid, first_err_vec, first_err_phase} !== {got.valid, got.vec, got.phase}) begin
      bad++;
      $display("FAIL %s_first_err: valid=%b vec=%0d phase=%b, required valid=%b vec=%0d phase=%b",
               name, first_err_valid, first_err_vec, first_err_phase, got.valid, got.vec, got.phase);
    end
    total++;
    if (pass !== got.pass) begin
      bad++;
      $display("FAIL %s_pass: got %b, required %b", name, pass, got.pass);
    end
    total++;
    if (int'(err_cnt) != mon_err) begin
      bad++;
      $display("FAIL %s_err_vs_samples: err_cnt=%0d, observed bad samples=%0d", name, err_cnt, mon_err);
    end
    total++;
    if (hold_viol != 0) begin
      bad++;
      $display("FAIL %s_hold_window: got %0d violations, required 0", name, hold_viol);
    end
  endtask

  task automatic test_clean_sweep();
    run_sweep("clean", 0, '{err: 0, vec: 9'd0, phase: 1'b0, valid: 1'b0, pass: 1'b1}, 1'b0);
    total++;
    if (last_r_q !== 10'h01F || last_c_q !== 10'h3E0) begin
      bad++;
      $display("FAIL boundary_511: R q=%h C q=%h, required 01f 3e0", last_r_q, last_c_q);
    end
  endtask

  task automatic test_start_ignored();
    run_sweep("start_busy", 0, '{err: 0, vec: 9'd0, phase: 1'b0, valid: 1'b0, pass: 1'b1}, 1'b1);
  endtask

  task automatic test_stuck_bit();
    run_sweep("stuck", 1, '{err: 256, vec: 9'd1, phase: 1'b1, valid: 1'b1, pass: 1'b0}, 1'b0);
  endtask

  task automatic test_restart_from_done();
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (err_cnt !== 11'd0 || done !== 1'b0 || busy !== 1'b1 || first_err_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart_clear: err_cnt=%0d done=%b busy=%b fev=%b, required 0 0 1 0",
               err_cnt, done, busy, first_err_valid);
    end
    for (int i = 0; i < SWEEP + 200 && !done; i++) @(negedge clk);
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++;
      $display("FAIL restart_result: done=%b pass=%b, required 1 1", done, pass);
    end
  endtask

  task automatic test_unzeroed();
    run_sweep("unzeroed", 2, '{err: 511, vec: 9'd1, phase: 1'b1, valid: 1'b1, pass: 1'b0}, 1'b0);
  endtask

  task automatic test_reset_midsweep();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (999) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({busy, done, pass, err_cnt, first_err_vec, first_err_phase, first_err_valid,
         dp.a, dp.b, dp.Cin, dp.sel, dp.load} !== '0) begin
      bad++;
      $display("FAIL midsweep_reset: busy=%b err_cnt=%0d a=%h b=%h load=%b, required all zero",
               busy, err_cnt, dp.a, dp.b, dp.load);
    end
    repeat (30) @(negedge clk);
    total++;
    if (busy !== 1'b0 || dp.load !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midsweep_idle: busy=%b load=%b done=%b, required 0 0 0", busy, dp.load, done);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_start_ignored();
    test_stuck_bit();
    test_restart_from_done();
    test_unzeroed();
    test_reset_midsweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
